// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the DE2-115 SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WCNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WRITE_END
  } state_e;

endpackage

// File: rtl/sram_dq_io.sv
// Tri-state SRAM data pad: registered write data and enable, registered read capture.
module sram_dq_io
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_oe,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_capture,
  output logic [DATA_W-1:0] o_rdata,
  inout  wire  [DATA_W-1:0] io_dq
);

  logic              r_oe;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  assign io_dq   = r_oe ? r_wdata : {DATA_W{1'bz}};
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oe    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_oe <= i_oe;
      if (i_load) begin
        r_wdata <= i_wdata;
      end
      if (i_capture) begin
        r_rdata <= io_dq;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a fixed-priority VGA reader and a UART writer.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic              pixel_clk,
  input  logic              R,
  input  logic              stop,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WR_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_vga_grant;
  logic              w_wr_grant;
  logic              w_dq_oe_nxt;
  logic              w_capture;
  logic              r_vga_ack;
  logic              r_wr_ack;
  logic              r_rvalid;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_addr;

  always_comb begin
    w_vga_grant = (r_state == ST_IDLE) && vga_req;
    w_wr_grant  = (r_state == ST_IDLE) && !vga_req && wr_req && !stop;
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_vga_grant) begin
          w_state_nxt = ST_READ;
        end else if (w_wr_grant) begin
          w_state_nxt = ST_WRITE;
          w_wcnt_nxt  = WCNT_LOAD;
        end
      end
      ST_READ: w_state_nxt = ST_IDLE;
      ST_WRITE: begin
        if (r_wcnt == '0) begin
          w_state_nxt = ST_WRITE_END;
        end else begin
          w_wcnt_nxt = r_wcnt - 1'b1;
        end
      end
      ST_WRITE_END: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Driver stays on through WRITE_END for data hold; released as IDLE is re-entered.
  assign w_dq_oe_nxt = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_WRITE_END);
  assign w_capture   = (r_state == ST_READ);

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= '0;
      r_vga_ack <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_vga_ack <= w_vga_grant;
      r_wr_ack  <= w_wr_grant;
      r_rvalid  <= w_capture;
      r_ce_n    <= 1'b0;
      r_oe_n    <= !w_vga_grant;
      r_we_n    <= (w_state_nxt != ST_WRITE);
      if (w_vga_grant) begin
        r_addr <= vga_addr;
      end else if (w_wr_grant) begin
        r_addr <= wr_addr;
      end
    end
  end

  sram_dq_io #(
    .DATA_W(DATA_W)
  ) u_dq_io (
    .i_clk    (pixel_clk),
    .i_rst    (R),
    .i_oe     (w_dq_oe_nxt),
    .i_load   (w_wr_grant),
    .i_wdata  (wr_data),
    .i_capture(w_capture),
    .o_rdata  (vga_rdata),
    .io_dq    (SRAM_DQ)
  );

  assign vga_ack    = r_vga_ack;
  assign vga_rvalid = r_rvalid;
  assign wr_ack     = r_wr_ack;
  assign busy       = (r_state != ST_IDLE);
  assign SRAM_ADDR  = r_addr;
  assign SRAM_CE_N  = r_ce_n;
  assign SRAM_UB_N  = r_ce_n;
  assign SRAM_LB_N  = r_ce_n;
  assign SRAM_OE_N  = r_oe_n;
  assign SRAM_WE_N  = r_we_n;

endmodule
